// File: rtl/reservation_station.sv
// Reservation station: holds dispatched instructions until both operands are ready, then issues one per cycle.
// Optional macro RS_AGE_ORDER_EN: issue the oldest ready entry instead of the lowest-index one.
module reservation_station #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  op_in,
  input  logic [31:0] value1_in,
  input  logic [31:0] value2_in,
  input  logic [2:0]  query1_in,
  input  logic [2:0]  query2_in,
  input  logic [2:0]  target_in,
  input  logic [31:0] imm_in,
  input  logic [2:0]  alu_num,
  input  logic [31:0] alu_value,
  input  logic [2:0]  mem_num,
  input  logic [31:0] mem_value,
  output logic        rs_full,
  output logic [4:0]  alu_op,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [31:0] alu_imm,
  output logic [2:0]  alu_target
);

  localparam logic [4:0] NOP = 5'b11111;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] busy;
  logic [4:0]       op   [DEPTH];
  logic [31:0]      v1   [DEPTH];
  logic [31:0]      v2   [DEPTH];
  logic [31:0]      imm  [DEPTH];
  logic [2:0]       q1   [DEPTH];
  logic [2:0]       q2   [DEPTH];
  logic [2:0]       tgt  [DEPTH];
  logic [CW-1:0]    count;
`ifdef RS_AGE_ORDER_EN
  // age = number of still-resident entries inserted earlier (0 = oldest)
  logic [IW-1:0]    age  [DEPTH];
`endif

  logic [DEPTH-1:0] ready;
  logic             issue_valid;
  logic [IW-1:0]    issue_idx;
  logic             ins_valid;
  logic [IW-1:0]    ins_idx;
  logic [CW-1:0]    cnt_next;

  // Resolve a tag against this cycle's broadcasts; ALU wins when both match.
  function automatic logic [34:0] wake(input logic [2:0] q, input logic [31:0] v);
    if (q != 3'd0 && q == alu_num) return {3'd0, alu_value};
    if (q != 3'd0 && q == mem_num) return {3'd0, mem_value};
    return {q, v};
  endfunction

  always_comb begin
    for (int i = 0; i < DEPTH; i++)
      ready[i] = busy[i] && (q1[i] == 3'd0) && (q2[i] == 3'd0);
  end

  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
`ifdef RS_AGE_ORDER_EN
    for (int i = 0; i < DEPTH; i++) begin
      if (ready[i] && (!issue_valid || age[i] < age[issue_idx])) begin
        issue_valid = 1'b1;
        issue_idx   = IW'(i);
      end
    end
`else
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ready[i]) begin
        issue_valid = 1'b1;
        issue_idx   = IW'(i);
      end
    end
`endif
  end

  // The slot being issued this edge counts as free, so it can be refilled immediately.
  always_comb begin
    ins_valid = 1'b0;
    ins_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy[i] || (issue_valid && issue_idx == IW'(i))) begin
        ins_valid = (op_in != NOP);
        ins_idx   = IW'(i);
      end
    end
    cnt_next = count + CW'(ins_valid) - CW'(issue_valid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      count      <= '0;
      rs_full    <= 1'b0;
      alu_op     <= NOP;
      alu_target <= 3'd0;
      alu_a      <= 32'd0;
      alu_b      <= 32'd0;
      alu_imm    <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        op[i]  <= NOP;
        v1[i]  <= 32'd0;
        v2[i]  <= 32'd0;
        imm[i] <= 32'd0;
        q1[i]  <= 3'd0;
        q2[i]  <= 3'd0;
        tgt[i] <= 3'd0;
`ifdef RS_AGE_ORDER_EN
        age[i] <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (busy[i]) begin
          {q1[i], v1[i]} <= wake(q1[i], v1[i]);
          {q2[i], v2[i]} <= wake(q2[i], v2[i]);
        end
      end

      if (issue_valid) begin
        busy[issue_idx] <= 1'b0;
        alu_op          <= op[issue_idx];
        alu_a           <= v1[issue_idx];
        alu_b           <= v2[issue_idx];
        alu_imm         <= imm[issue_idx];
        alu_target      <= tgt[issue_idx];
      end else begin
        alu_op     <= NOP;
        alu_target <= 3'd0;
      end

`ifdef RS_AGE_ORDER_EN
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_valid && busy[i] && age[i] > age[issue_idx])
          age[i] <= age[i] - IW'(1);
      end
`endif

      if (ins_valid) begin
        busy[ins_idx] <= 1'b1;
        op[ins_idx]   <= op_in;
        imm[ins_idx]  <= imm_in;
        tgt[ins_idx]  <= target_in;
        {q1[ins_idx], v1[ins_idx]} <= wake(query1_in, value1_in);
        {q2[ins_idx], v2[ins_idx]} <= wake(query2_in, value2_in);
`ifdef RS_AGE_ORDER_EN
        age[ins_idx]  <= IW'(cnt_next - CW'(1));
`endif
      end

      count   <= cnt_next;
      rs_full <= (cnt_next >= CW'(DEPTH - 1));
    end
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 Parameter: DEPTH, 4, number of entries (2..8); rs_full asserts one entry early.
REQ-002 clk  input  1  single clock; all state updates on posedge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op_in  input  5  dispatched opcode from ROB; 5'b11111 = no instruction.
REQ-005 value1_in, value2_in  input  32 each  operand values, valid when matching query is 0.
REQ-006 query1_in, query2_in  input  3 each  ROB tag awaited; 0 = operand ready.
REQ-007 target_in  input  3  ROB entry number of the instruction (1..7).
REQ-008 imm_in  input  32  immediate, carried unchanged to issue.
REQ-009 alu_num, mem_num  input  3 each  CDB tags (0 = no broadcast); alu_value, mem_value  input  32 each.
REQ-010 rs_full  output  1  back-pressure to ROB.
REQ-011 alu_op  output  5  issued opcode; 5'b11111 = no issue.
REQ-012 alu_a, alu_b, alu_imm  output  32 each  issued operands and immediate.
REQ-013 alu_target  output  3  ROB number of issued instruction; 0 when alu_op = 5'b11111.

Function
REQ-014 Entry fields: busy, op, v1, v2, q1, q2, target, imm, age (2-bit-wide-enough counter).
REQ-015 Insert on posedge when op_in != 5'b11111 and a free entry exists; lowest-index free entry is used.
REQ-016 Insert with no free entry is dropped; producer relies on rs_full, no error flag.
REQ-017 Wakeup: each posedge, every busy entry with q == alu_num (nonzero) takes v = alu_value, q = 0; likewise for mem_num/mem_value.
REQ-018 Insert bypass (mandatory): an incoming query equal to a same-cycle nonzero alu_num or mem_num is stored as ready with the broadcast value.
REQ-019 If alu_num == mem_num (nonzero), alu_value wins.
REQ-020 Entry is ready when busy and q1 == 0 and q2 == 0, evaluated on registered state.
REQ-021 Issue: at most one entry per cycle; ready in cycle N -> alu_* registered at posedge N+1, entry freed at same edge.
REQ-022 Insert-to-issue latency with both operands ready at insert: 1 cycle (alu_* valid after the 2nd posedge following op_in).
REQ-023 No ready entry: alu_op = 5'b11111, alu_target = 0; alu_a/alu_b/alu_imm hold previous value.
REQ-024 Freed entry may be reused by an insert on the same posedge.
REQ-025 rs_full = (busy count after this edge's insert/issue) >= DEPTH-1, registered.
REQ-026 Occupancy count never exceeds DEPTH nor underflows below 0.

Reset
REQ-027 On posedge with rst = 1: all busy = 0, rs_full = 0, alu_op = 5'b11111, alu_target = 0, alu_a = alu_b = alu_imm = 0, count = 0, ages = 0.
REQ-028 Reset mid-operation discards all entries and any same-cycle insert or issue; rst overrides all inputs.

Configuration
REQ-029 Macro RS_AGE_ORDER_EN defined: issue selects the oldest ready entry (smallest insert order, ages updated on insert/issue).
REQ-030 Macro RS_AGE_ORDER_EN undefined: issue selects the lowest-index ready entry; age fields absent.

Verification
REQ-031 rst 1 cycle -> rs_full=0, alu_op=5'b11111, alu_target=0, alu_a=0.
REQ-032 Insert ADD(5'b00000) v1=5 v2=7 q=0 target=3 -> next cycle alu_op=00000, alu_a=5, alu_b=7, alu_target=3.
REQ-033 Insert SUB q1=2 target=4; two cycles later alu_num=2 alu_value=0x10 -> issue next cycle alu_a=0x10, alu_target=4.
REQ-034 Insert q2=5 in same cycle as mem_num=5 mem_value=0xABCD -> issues next cycle with alu_b=0xABCD (bypass).
REQ-035 Insert 3 blocked entries (DEPTH=4) -> rs_full=1 after 3rd insert; wake one -> issue, rs_full falls.
REQ-036 With RS_AGE_ORDER_EN: entries target 5 (index 1, older) and target 6 (index 0, reused, younger) woken same cycle -> target 5 issues first; without macro target 6 first.
